// File: rtl/seq_detect_param.sv
// Programmable-length serial pattern detector with runtime-loadable pattern,
// selectable overlap and Mealy/Moore output, and a saturating match counter.
module seq_detect_param #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1,
  parameter int MEALY   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_pattern;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_count;
  logic              r_y;

  logic [PAT_W-1:0]  w_hist_next;
  logic [FILL_W-1:0] w_fill_next;
  logic              w_hit;
  logic              w_sat;

  // Newest bit enters at the LSB, so the oldest bit lines up with pattern MSB.
  assign w_hist_next = {r_hist[PAT_W-2:0], x};
  assign w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
  assign w_hit       = en & ~load & ~reset & (w_fill_next == FILL_FULL) &
                       (w_hist_next == r_pattern);
  assign w_sat       = &r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (load) begin
      // The bit presented alongside load is dropped on purpose.
      r_pattern <= pattern_in;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (en) begin
      r_hist <= w_hist_next;
      r_fill <= (w_hit && OVERLAP == 0) ? '0 : w_fill_next;
    end
  end

  // Clear beats a coincident hit; the hit still shows on y.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      r_count <= '0;
    end else if (w_hit && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_hit;
    end
  end

  assign y           = (MEALY != 0) ? w_hit : r_y;
  assign match_count = r_count;
  assign count_sat   = w_sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Drives four detector configurations from one stimulus stream and checks each
// against a stream-level reference model (accepted-bit history plus window compare).
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset, en, x, load, cnt_clr;
  logic [3:0] pattern_in;

  logic       y0, y1, y2, y3;
  logic [7:0] mc0, mc1, mc2;
  logic [1:0] mc3;
  logic       s0, s1, s2, s3;

  always #5 clk = ~clk;

  // 0: overlap/Mealy  1: no-overlap/Mealy  2: overlap/Moore  3: overlap/Mealy, 2-bit counter
  seq_detect_param #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .MEALY(1)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .cnt_clr(cnt_clr), .y(y0), .match_count(mc0), .count_sat(s0));
  seq_detect_param #(.PAT_W(4), .CNT_W(8), .OVERLAP(0), .MEALY(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .cnt_clr(cnt_clr), .y(y1), .match_count(mc1), .count_sat(s1));
  seq_detect_param #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .MEALY(0)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .cnt_clr(cnt_clr), .y(y2), .match_count(mc2), .count_sat(s2));
  seq_detect_param #(.PAT_W(4), .CNT_W(2), .OVERLAP(1), .MEALY(1)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .cnt_clr(cnt_clr), .y(y3), .match_count(mc3), .count_sat(s3));

  // Reference model: every accepted bit in order, plus per-config start index
  // of the bits still eligible to form a match.
  int stream[$];
  int start[4];
  int cnt[4];
  int cmax[4] = '{255, 255, 255, 3};
  int prev_hit2;
  int mpat;
  bit hit[4];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic step(input bit e, input bit xi, input bit ld, input bit cc,
                      input bit rs, input logic [3:0] p);
    int sz;
    int win;
    en = e; x = xi; load = ld; cnt_clr = cc; reset = rs; pattern_in = p;
    #1;
    sz  = stream.size();
    win = -1;
    if (sz >= 3)
      win = (stream[sz-3] << 3) | (stream[sz-2] << 2) | (stream[sz-1] << 1) | int'(xi);
    for (int k = 0; k < 4; k++)
      hit[k] = e && !ld && !rs && (sz + 1 - start[k] >= 4) && (win == mpat);

    check("y",   0, 32'(y0), 32'(hit[0]));
    check("y",   1, 32'(y1), 32'(hit[1]));
    check("y",   2, 32'(y2), 32'(prev_hit2));
    check("y",   3, 32'(y3), 32'(hit[3]));
    check("cnt", 0, 32'(mc0), 32'(cnt[0]));
    check("cnt", 1, 32'(mc1), 32'(cnt[1]));
    check("cnt", 2, 32'(mc2), 32'(cnt[2]));
    check("cnt", 3, 32'(mc3), 32'(cnt[3]));
    check("sat", 0, 32'(s0), 32'(cnt[0] == cmax[0]));
    check("sat", 3, 32'(s3), 32'(cnt[3] == cmax[3]));

    @(posedge clk);
    if (rs) begin
      mpat = 0;
      prev_hit2 = 0;
      for (int k = 0; k < 4; k++) begin
        cnt[k]   = 0;
        start[k] = stream.size();
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cc) cnt[k] = 0;
        else if (hit[k] && cnt[k] < cmax[k]) cnt[k]++;
      end
      prev_hit2 = int'(hit[2]);
      if (ld) begin
        mpat = int'(p);
        for (int k = 0; k < 4; k++) start[k] = stream.size();
      end else if (e) begin
        stream.push_back(int'(xi));
        if (hit[1]) start[1] = stream.size();
      end
    end
    @(negedge clk);
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; cnt_clr = 1'b0; pattern_in = 4'h0;
    mpat = 0; prev_hit2 = 0;
    for (int k = 0; k < 4; k++) begin start[k] = 0; cnt[k] = 0; end
    @(posedge clk); @(negedge clk);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);              // reset state
    // Plan 1/2: overlap vs no-overlap, then bits 8..11
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011);
    feed(32'b1011011, 7);
    feed(32'b1011, 4);
    // Plan 3: Moore latency with en=0 gaps
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    // Plan 4: load with en=1 discards the bit and the partial history
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011);
    feed(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    feed(32'b1011, 4);
    // Plan 5: saturation of the 2-bit counter, then clear coincident with a hit
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
    feed(32'h3ff, 10);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    feed(32'b11, 2);
    // Plan 6: reset mid-stream loses the partial pattern
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011);
    feed(32'b101, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    feed(32'b1, 1);
    feed(32'b0000, 4);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit e, xi, ld, cc, rs;
      logic [3:0] p;
      e  = ($urandom % 4) != 0;
      xi = 1'($urandom);
      ld = ($urandom % 40) == 0;
      cc = ($urandom % 50) == 0;
      rs = ($urandom % 250) == 0;
      p  = (($urandom % 2) == 0) ? 4'b1011 : 4'($urandom);
      step(e, xi, ld, cc, rs, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
